// File: rtl/sw_pattern_driver.sv
// sw_pattern_driver: walks every switch pattern, waits a settle time, and
// folds the LED responses into a 16-bit MISR. Gray order: SW_PATTERN_GRAY_EN.
module sw_pattern_driver #(
    parameter int          WIDTH   = 7,
    parameter int          RESP_W  = 2,
    parameter int          SETTLE  = 4,
    parameter logic [15:0] EXP_SIG = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [WIDTH-1:0]  sw_out,
    input  logic [RESP_W-1:0] led_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       signature,
    output logic [WIDTH-1:0]  pat_idx
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pattern;
    logic             fb;
    logic [15:0]      sig_nxt;
    logic             last;

    // Pattern for the current index plus the next MISR value
    always_comb begin
`ifdef SW_PATTERN_GRAY_EN
        pattern = pat_idx ^ (pat_idx >> 1);
`else
        pattern = pat_idx;
`endif
        fb      = signature[15] ^ signature[13] ^ signature[12] ^ signature[10];
        sig_nxt = {signature[14:0], fb} ^ 16'(led_in);
        last    = (pat_idx == LAST_IDX);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy      = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy      = 1'b1;
                state_nxt = last ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_APPLY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pattern bus, index, settle counter, signature and verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_out    <= '0;
            pat_idx   <= '0;
            signature <= 16'hFFFF;
            cnt       <= '0;
            pass      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pat_idx   <= '0;
                        signature <= 16'hFFFF;
                        pass      <= 1'b0;
                    end
                end
                S_APPLY: begin
                    sw_out <= pattern;
                    cnt    <= CNT_LOAD;
                end
                S_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_SAMPLE: begin
                    signature <= sig_nxt;
                    if (last) begin
                        sw_out <= '0;
                        pass   <= (sig_nxt == EXP_SIG);
                    end else begin
                        pat_idx <= pat_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
